// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types and constants for the seven-segment scanner.
// Holds the scan FSM state enum, active-low glyph patterns {g,f,e,d,c,b,a},
// the upstream overflow code, and the packed four-digit snapshot type.
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Overflow code produced by the upstream BCD calculator
  localparam logic [3:0] BCD_OVF = 4'hF;

  // Four BCD digits; element 0 is the least significant digit
  typedef logic [3:0][3:0] bcd4_t;

  // Active-low one-hot anode pattern for a digit index
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: digit inputs and display outputs of the scanner.
// Ports: BCD0..BCD3 digits, LzbEn, DpMask (upstream -> scanner);
//        An, Seg, Dp active-low display drives (scanner -> display).
interface seven_seg_scanner_if;

  logic [3:0] BCD0;
  logic [3:0] BCD1;
  logic [3:0] BCD2;
  logic [3:0] BCD3;
  logic       LzbEn;
  logic [3:0] DpMask;
  logic [3:0] An;
  logic [6:0] Seg;
  logic       Dp;

  // Upstream side: supplies digits and display controls, sees the drives
  modport master (
    output BCD0, BCD1, BCD2, BCD3, LzbEn, DpMask,
    input  An, Seg, Dp
  );

  // Scanner side
  modport slave (
    input  BCD0, BCD1, BCD2, BCD3, LzbEn, DpMask,
    output An, Seg, Dp
  );

endinterface

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low seven-segment decoder.
// Ports: bcd_i digit value, blank_i forces all segments off, seg_o {g,f,e,d,c,b,a}.
// 0-9 standard glyphs, overflow code shows a dash, A-E render blank.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      unique case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        BCD_OVF: seg_o = SEG_DASH;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 4-digit seven-segment driver.
// Ports: Clk, Reset (sync, active-high); bus (slave) carries BCD0..3, LzbEn,
//        DpMask in and active-low An/Seg/Dp out, all outputs registered.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int BLANK_CYCLES = 2,
  parameter int DRIVE_CYCLES = 100000
) (
  input  logic               Clk,
  input  logic               Reset,
  seven_seg_scanner_if.slave bus
);

  localparam int MAX_CYCLES = (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES : DRIVE_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       idx_q,   idx_d;
  bcd4_t            snap_q,  snap_d;
  logic             lzb_q,   lzb_d;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  logic [3:0] zero;
  logic       lz_blank;
  logic [6:0] seg_dec;

  // Next-state: counter, digit index and snapshot
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    snap_d  = snap_q;
    lzb_d   = lzb_q;
    unique case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
          // Whole frame is captured at once so digits never mix across frames
          if (idx_q == 2'd0) begin
            snap_d = {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0};
            lzb_d  = bus.LzbEn;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Leading-zero blanking on the digit about to be shown. Overflow code is
  // non-zero here, so a dash is never suppressed.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      zero[i] = (snap_d[i] == 4'd0);
    end
    unique case (idx_d)
      2'd3:    lz_blank = zero[3];
      2'd2:    lz_blank = zero[3] & zero[2];
      2'd1:    lz_blank = zero[3] & zero[2] & zero[1];
      default: lz_blank = 1'b0;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd_i   (snap_d[idx_d]),
    .blank_i (lzb_d & lz_blank),
    .seg_o   (seg_dec)
  );

  // Outputs derived from the next state so they switch on the entering edge
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state_d == DRIVE) begin
      an_d  = an_select(idx_d);
      seg_d = seg_dec;
      dp_d  = ~bus.DpMask[idx_d];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= '0;
      lzb_q   <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      lzb_q   <= lzb_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.An  = an_q;
  assign bus.Seg = seg_q;
  assign bus.Dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scenario tasks checked against a timeline model.
// The model tracks edges since reset and derives digit/phase by arithmetic.
// Inputs change on negedge; outputs compared on negedge.
module tb_seven_seg_scanner;

  localparam int B = 2;
  localparam int D = 4;
  localparam int P = B + D;
  localparam int F = 4 * P;

  logic Clk;
  logic Reset;

  seven_seg_scanner_if bus ();

  seven_seg_scanner #(
    .BLANK_CYCLES (B),
    .DRIVE_CYCLES (D)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total;
  int bad;

  // Reference timeline: m_k = edges since reset released
  int         m_k;
  logic [3:0] m_snap [4];
  logic       m_lzb;
  logic [3:0] m_dp;

  always @(posedge Clk) begin
    int nk;
    if (Reset) begin
      m_k <= 0;
      m_lzb <= 1'b0;
      for (int i = 0; i < 4; i++) m_snap[i] <= 4'd0;
    end else begin
      nk = m_k + 1;
      m_k <= nk;
      if (nk % F == B) begin
        m_snap[0] <= bus.BCD0;
        m_snap[1] <= bus.BCD1;
        m_snap[2] <= bus.BCD2;
        m_snap[3] <= bus.BCD3;
        m_lzb     <= bus.LzbEn;
      end
    end
    m_dp <= bus.DpMask;
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      4'hF: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {An, Seg, Dp} after the most recent edge
  function automatic logic [11:0] exp_out();
    int q, d, w;
    logic blank;
    logic [3:0] an;
    q = m_k % F;
    d = q / P;
    w = q % P;
    if (w < B) return {4'b1111, 7'b1111111, 1'b1};
    blank = 1'b0;
    if (m_lzb && d > 0) begin
      blank = 1'b1;
      for (int j = d; j < 4; j++) if (m_snap[j] != 4'd0) blank = 1'b0;
    end
    an = 4'b0001 << d;
    return {~an, blank ? 7'b1111111 : glyph(m_snap[d]), ~m_dp[d]};
  endfunction

  function automatic bit in_drive_of(input int dig);
    int q;
    q = m_k % F;
    return (q / P == dig) && (q % P >= B);
  endfunction

  task automatic set_bcd(input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0);
    bus.BCD3 = d3; bus.BCD2 = d2; bus.BCD1 = d1; bus.BCD0 = d0;
  endtask

  task automatic restart();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    got = {bus.An, bus.Seg, bus.Dp};
    total++;
    if (got !== 12'hFFF) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", got, 12'hFFF);
    end
    Reset = 1'b0;
  endtask

  task automatic test_scan_basic();
    logic [11:0] got, exp;
    set_bcd(4'd3, 4'd2, 4'd1, 4'd0);
    bus.LzbEn = 1'b0; bus.DpMask = 4'b0000;
    restart();
    for (int c = 0; c < 2 * F; c++) begin
      @(negedge Clk);
      got = {bus.An, bus.Seg, bus.Dp};
      exp = exp_out();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL scan_basic cyc=%0d got=%b want=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [11:0] got, exp;
    set_bcd(4'hF, 4'hF, 4'hF, 4'hF);
    bus.LzbEn = 1'b1;
    restart();
    for (int c = 0; c < F; c++) begin
      @(negedge Clk);
      got = {bus.An, bus.Seg, bus.Dp};
      exp = exp_out();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL overflow_dash cyc=%0d got=%b want=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_lzb();
    logic [11:0] got, exp;
    bus.LzbEn = 1'b1;
    set_bcd(4'd0, 4'd0, 4'd4, 4'd0);
    restart();
    for (int c = 0; c < 2 * F; c++) begin
      @(negedge Clk);
      got = {bus.An, bus.Seg, bus.Dp};
      exp = exp_out();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL lzb_0040 cyc=%0d got=%b want=%b", c, got, exp);
      end
      if (c == F - 2) set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
    end
  endtask

  task automatic test_midframe_change();
    logic [11:0] got, exp;
    int budget;
    bus.LzbEn = 1'b0;
    set_bcd(4'd1, 4'd2, 4'd3, 4'd4);
    restart();
    budget = 0;
    while (!in_drive_of(2) && budget < 2 * F) begin
      @(negedge Clk);
      budget++;
    end
    total++;
    if (!in_drive_of(2)) begin
      bad++;
      $display("FAIL midframe_wait got=timeout want=digit2");
    end
    set_bcd(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
    for (int c = 0; c < 2 * F; c++) begin
      @(negedge Clk);
      got = {bus.An, bus.Seg, bus.Dp};
      exp = exp_out();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL midframe_change cyc=%0d got=%b want=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] got;
    int budget;
    bus.LzbEn = 1'b0; bus.DpMask = 4'b0000;
    set_bcd(4'd7, 4'd8, 4'd9, 4'd0);
    restart();
    budget = 0;
    while (!in_drive_of(2) && budget < 2 * F) begin
      @(negedge Clk);
      budget++;
    end
    Reset = 1'b1;
    @(negedge Clk);
    got = {bus.An, bus.Seg, bus.Dp};
    total++;
    if (got !== 12'hFFF) begin
      bad++;
      $display("FAIL reset_mid got=%b want=%b", got, 12'hFFF);
    end
    Reset = 1'b0;
    repeat (B) @(negedge Clk);
    got = {bus.An, bus.Seg, bus.Dp};
    total++;
    if (got !== {4'b1110, 7'b1000000, 1'b1}) begin
      bad++;
      $display("FAIL reset_first_digit got=%b want=%b", got, {4'b1110, 7'b1000000, 1'b1});
    end
  endtask

  task automatic test_dp();
    logic [11:0] got, exp;
    set_bcd(4'd5, 4'd6, 4'd7, 4'd8);
    bus.LzbEn = 1'b0; bus.DpMask = 4'b0100;
    restart();
    for (int c = 0; c < F + B; c++) begin
      @(negedge Clk);
      got = {bus.An, bus.Seg, bus.Dp};
      exp = exp_out();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL dp_mask cyc=%0d got=%b want=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] got, exp;
    restart();
    for (int c = 0; c < 6 * F; c++) begin
      @(negedge Clk);
      got = {bus.An, bus.Seg, bus.Dp};
      exp = exp_out();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", c, got, exp);
      end
      if ($urandom_range(0, 7) == 0)
        set_bcd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 15) == 0) bus.LzbEn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bus.DpMask = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b1;
    set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
    bus.LzbEn  = 1'b0;
    bus.DpMask = 4'b0000;
    test_reset();
    test_scan_basic();
    test_overflow();
    test_lzb();
    test_midframe_change();
    test_reset_mid();
    test_dp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed 4-digit seven-segment driver that sits directly downstream of the BCD calculator stage and consumes its four BCD digit outputs. It snapshots the digits once per scan frame, decodes them to active-low segment patterns, and drives one anode at a time. A blanking gap between digits prevents ghosting. The calculator's overflow code 4'hF is rendered as a dash.

## Interface
- BLANK_CYCLES, 2, cycles all anodes are off before each digit is driven (≥1)
- DRIVE_CYCLES, 100000, cycles each digit is driven (≥1)
- Clk  in  1  system clock; all logic on posedge
- Reset  in  1  synchronous, active-high
- BCD0..BCD3  in  4 each  digit values from the upstream stage; BCD0 is least significant
- LzbEn  in  1  leading-zero blanking enable
- DpMask  in  4  decimal point enable per digit; bit i maps to digit i
- An  out  4  anode selects, active-low, one-hot-low or all-high
- Seg  out  7  {g,f,e,d,c,b,a}, active-low
- Dp  out  1  decimal point, active-low

## Operation
- FSM has two states: BLANK and DRIVE.
- State registers:
  - cnt: cycle counter within the current state
  - idx: 2-bit digit index
  - snapshot: four 4-bit BCD values
- State transitions:
  - BLANK lasts BLANK_CYCLES cycles, then goes to DRIVE.
  - DRIVE lasts DRIVE_CYCLES cycles, then goes to BLANK with idx+1. idx wraps 3→0.
  - cnt clears on every state change.
- Snapshot: all four BCD inputs and LzbEn are latched together on the BLANK→DRIVE edge when idx=0. No other edge updates the snapshot, so a frame never shows mixed old and new digits.
- Decode:
  - Values 0–9 use standard glyphs.
  - 4'hF shows a dash (Seg=7'b0111111).
  - 4'hA–4'hE are blank (7'b1111111).
- Leading-zero blanking (uses the latched LzbEn):
  - Digit 3 is blank if snap3==0.
  - Digit 2 is blank if snap3==0 and snap2==0.
  - Digit 1 is blank if snap3, snap2 and snap1 are all 0.
  - Digit 0 is never blanked.
  - 4'hF is never treated as zero.
- In DRIVE: An[idx]=0 and all other anodes are 1. Seg shows the decoded snapshot digit. Dp=~DpMask[idx], read live. When a digit is blanked, Seg is 7'b1111111 while its anode stays asserted.
- In BLANK: An=4'b1111, Seg=7'b1111111, Dp=1.

## Timing
- All outputs are registered and computed from the next state. They change on the same edge that enters a state.
- Reset values:
  - State BLANK, idx=0, cnt=0, snapshot all 0
  - An=4'b1111, Seg=7'b1111111, Dp=1
- First DRIVE of digit 0 starts BLANK_CYCLES edges after Reset deasserts.
- Frame length is 4×(BLANK_CYCLES+DRIVE_CYCLES) cycles.
- Input-to-display latency: a BCD change is displayed at the next idx=0 BLANK→DRIVE edge, at most one frame plus BLANK_CYCLES later.
- Reset asserted mid-frame: on the next edge, all state and outputs take their reset values. The snapshot is cleared, and no partial digit period completes.
- Simultaneous input change and snapshot edge: the value sampled at that edge is captured.
- cnt width is $clog2(max(BLANK_CYCLES, DRIVE_CYCLES)). It must not overflow at DRIVE_CYCLES=100000 (17 bits).

## Structure
- Package seven_seg_pkg holds:
  - state enum {BLANK, DRIVE}
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
  - BCD_OVF = 4'hF
- Sub-module bcd_to_seg: combinational BCD-to-segment decoder with a blank input.
- FSM, counters, snapshot and leading-zero logic stay in seven_seg_scanner.

## Test plan
- Reset release, BLANK=2, DRIVE=4, BCD=3,2,1,0 (digits 3..0) → An steps 1110, 1101, 1011, 0111. Each is low for 4 cycles with 2 all-high cycles between. Seg shows 1000000, 1111001, 0100100, 0110000 in turn; frame is 24 cycles.
- BCD=all 4'hF → every digit Seg=0111111 and all four anodes are activated.
- LzbEn=1, BCD3..0=0,0,4,0 → digits 3 and 2 are blank with their anodes asserted; digit 1 shows "4" and digit 0 shows "0". With 0,0,0,0 → only digit 0 lit, showing "0".
- Change BCD while idx=2 → display unchanged until the next idx=0 DRIVE entry, then the new value is shown on all digits.
- Assert Reset during DRIVE of digit 2 → next edge An=1111, Seg=1111111, Dp=1. After release, the first lit digit is digit 0 and shows "0".
- DpMask=4'b0100 → Dp=0 only while An=1011; Dp=1 during all BLANK cycles.
